instr_queue_reg: RTL and testbench

INSTR_QUEUE_REG -- requirements
Module: instr_queue_reg

---
 rtl/instr_queue_reg.sv | 105 ++++++++++
 tb/tb_instr_queue_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_queue_reg.sv
// Instruction prefetch FIFO feeding an instruction register,
// with combinational field decode taken straight from the IR.
module instr_queue_reg #(
    parameter int IW    = 16,
    parameter int DEPTH = 4,
    parameter int OPW   = 4,
    parameter int RW    = 3
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [IW-1:0]                in_data,
    output logic                         in_ready,
    input  logic                         ir_write,
    output logic                         ir_valid,
    output logic [OPW-1:0]               op,
    output logic [RW-1:0]                rs,
    output logic [RW-1:0]                rt,
    output logic [RW-1:0]                rd,
    output logic [RW-1:0]                funk,
    output logic [2*RW-1:0]              i_imm,
    output logic [IW-1:0]                i_imm_sx,
    output logic [IW-OPW-1:0]            j_imm,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [IW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          vld_q, vld_d;
    logic          push, pop;

    assign in_ready = (cnt_q < FULL) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = ir_write && (cnt_q != '0) && !flush;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        ir_d  = ir_q;
        vld_d = vld_q;
        if (flush) begin
            // Redirect: drop everything queued, keep the old IR bits
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
            vld_d = 1'b0;
        end else begin
            if (push)
                wp_d = wp_q + 1'b1;
            if (pop) begin
                ir_d  = mem_q[rp_q];
                vld_d = 1'b1;
                rp_d  = rp_q + 1'b1;
            end else if (ir_write) begin
                vld_d = 1'b0;
            end
            if (push && !pop)
                cnt_d = cnt_q + 1'b1;
            else if (pop && !push)
                cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ir_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ir_q  <= ir_d;
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem_q[wp_q] <= in_data;
    end

    assign ir_valid = vld_q;
    assign count    = cnt_q;
    assign op       = ir_q[IW-1 -: OPW];
    assign rs       = ir_q[IW-OPW-1 -: RW];
    assign rt       = ir_q[IW-OPW-RW-1 -: RW];
    assign rd       = ir_q[IW-OPW-2*RW-1 -: RW];
    assign funk     = ir_q[RW-1:0];
    assign i_imm    = ir_q[2*RW-1:0];
    assign i_imm_sx = {{(IW-2*RW){ir_q[2*RW-1]}}, ir_q[2*RW-1:0]};
    assign j_imm    = ir_q[IW-OPW-1:0];

endmodule

// File: tb/tb_instr_queue_reg.sv
// Scoreboard bench for instr_queue_reg: queued words are pushed to
// a model FIFO and checked field by field when they reach the IR.
module tb_instr_queue_reg;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        ir_write = 1'b0;
    logic        ir_valid;
    logic [3:0]  op;
    logic [2:0]  rs, rt, rd, funk;
    logic [5:0]  i_imm;
    logic [15:0] i_imm_sx;
    logic [11:0] j_imm;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] sb[$];
    int          mcnt = 0;
    logic        mvld = 1'b0;
    logic [15:0] mir = '0;

    instr_queue_reg dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ir_write(ir_write), .ir_valid(ir_valid),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .funk(funk),
        .i_imm(i_imm), .i_imm_sx(i_imm_sx), .j_imm(j_imm),
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_ir(input logic [15:0] w);
        logic [15:0] sx;
        sx = {{10{w[5]}}, w[5:0]};
        check("op", 32'(op), 32'(w[15:12]));
        check("rs", 32'(rs), 32'(w[11:9]));
        check("rt", 32'(rt), 32'(w[8:6]));
        check("rd", 32'(rd), 32'(w[5:3]));
        check("funk", 32'(funk), 32'(w[2:0]));
        check("i_imm", 32'(i_imm), 32'(w[5:0]));
        check("i_imm_sx", 32'(i_imm_sx), 32'(sx));
        check("j_imm", 32'(j_imm), 32'(w[11:0]));
    endtask

    // One clock of stimulus; inputs change 1 time unit after posedge
    task automatic step(input logic v, input logic [15:0] d,
                        input logic w, input logic f);
        logic rdy, psh, pp;
        in_valid = v;
        in_data  = d;
        ir_write = w;
        flush    = f;
        #1;
        rdy = (mcnt < 4) && !f;
        check("in_ready", 32'(in_ready), 32'(rdy));
        psh = v && rdy;
        pp  = w && (mcnt > 0) && !f;
        if (f) begin
            sb.delete();
            mcnt = 0;
            mvld = 1'b0;
        end else begin
            if (pp) begin
                mir  = sb.pop_front();
                mvld = 1'b1;
            end else if (w) begin
                mvld = 1'b0;
            end
            if (psh) sb.push_back(d);
            mcnt = mcnt + (psh ? 1 : 0) - (pp ? 1 : 0);
        end
        @(posedge clock);
        #1;
        check("count", 32'(count), 32'(mcnt));
        check("ir_valid", 32'(ir_valid), 32'(mvld));
        check_ir(mir);
        in_valid = 1'b0;
        ir_write = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_op", 32'(op), 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);

        // Decode of a known word
        step(1'b1, 16'h1A5F, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("dec_op", 32'(op), 32'h1);
        check("dec_rs", 32'(rs), 32'h5);
        check("dec_rt", 32'(rt), 32'h1);
        check("dec_rd", 32'(rd), 32'h3);
        check("dec_funk", 32'(funk), 32'h7);
        check("dec_iimm", 32'(i_imm), 32'h1F);
        check("dec_sx", 32'(i_imm_sx), 32'h001F);
        check("dec_jimm", 32'(j_imm), 32'hA5F);
        check("dec_valid", 32'(ir_valid), 32'h1);
        // Negative immediate sign-extends
        step(1'b1, 16'h0FE5, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("neg_sx", 32'(i_imm_sx), 32'hFFE5);

        // Fill past full: fifth word dropped
        for (int i = 1; i <= 5; i++)
            step(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
        check("full_cnt", 32'(count), 32'd4);
        // Full with a pop: push still blocked
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 16'h0000, 1'b1, 1'b0);
        // Empty pop is a bubble
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Steady push+pop at count 2, pointers wrap
        step(1'b1, 16'h4100, 1'b0, 1'b0);
        step(1'b1, 16'h4201, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'h5000 + 16'(i * 16'h0111), 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Bubble with same-cycle push, no bypass
        step(1'b1, 16'h2000, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h3000, 1'b1, 1'b0);
        check("nobyp_op", 32'(op), 32'h2);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("later_op", 32'(op), 32'h3);

        // Flush beats push and pop
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'h6000 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'h7777, 1'b1, 1'b1);
        check("fl_op", 32'(op), 32'h3);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h8123, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'h9000 + 16'(i), 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_cnt", 32'(count), 32'd0);
        check("arst_vld", 32'(ir_valid), 32'd0);
        check("arst_op", 32'(op), 32'd0);
        sb.delete();
        mcnt = 0;
        mvld = 1'b0;
        mir  = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        step(1'b1, 16'hA5A5, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
